pong_renderer: RTL and testbench
================================

# pong_renderer

Game engine and pixel generator for the Pong display path. It sits directly downstream of the VGA timing generator and consumes its 12-bit `h_cnt`/`v_cnt` and `enable`. It keeps paddle, ball and score state, updating once per frame, and emits registered 12-bit RGB for every pixel clock.

## Interface
- `BALL_SIZE`, 8: ball edge length in pixels (square ball).
- `PADDLE_W`, 8: paddle width in pixels.
- `PADDLE_H`, 64: paddle height in pixels.
- `PADDLE_SPEED`, 4: paddle pixels moved per frame.
- `BALL_SPEED`, 2: ball pixels moved per frame on each axis.
- `WIN_SCORE`, 9: score that ends the game (≤15).
- `SERVE_FRAMES`, 60: frames the ball is held at centre before a serve.

Ports:
- `clk`, in, 1: pixel clock (25 MHz).
- `rst`, in, 1: asynchronous, active-low reset.
- `h_cnt`, in, 12: horizontal counter, 0..799, active pixels at 144..783.
- `v_cnt`, in, 12: vertical counter, 0..524, active lines at 35..514.
- `enable`, in, 1: upstream active-area qualifier.
- `start`, in, 1: level; begins or restarts a game.
- `p1_up`, `p1_down`, `p2_up`, `p2_down`, in, 1 each: debounced, synchronous button levels. p1 is the left player.
- `rgb`, out, 12: registered pixel colour {R[3:0],G[3:0],B[3:0]}.
- `score_l`, `score_r`, out, 4 each: player scores.
- `game_over`, out, 1: high while in state OVER.

## Operation
- Pixel coordinates: x = h_cnt−144, y = v_cnt−35.
- A pixel is drawn only if `enable` is high, x<640 and y<480. Otherwise `rgb`=0. This applies even when `enable` is high at x=640 or y=480.
- `frame_tick`: a one-cycle internal strobe when h_cnt==799 and v_cnt==524. All game state, and all button and `start` sampling, updates only on `frame_tick`.
- Paddle geometry: the left paddle occupies x 16..16+PADDLE_W−1; the right paddle occupies x 616..616+PADDLE_W−1. Paddle tops `pl_y`/`pr_y` (10-bit) reset to 208.
- Paddle motion:
  - Up alone moves the paddle by −PADDLE_SPEED; down alone moves it by +PADDLE_SPEED. Both or neither pressed: the paddle holds.
  - The top is clamped to 0..480−PADDLE_H. Arithmetic is done at 11 bits, with no wrap.
- Ball state: top-left `bx`/`by` (10-bit) and direction bits `dx` (1 = right) and `dy` (1 = down).
- FSM states: IDLE, SERVE, PLAY, POINT, OVER.
  - IDLE: the ball is centred at (316,236). `start` moves to SERVE with dx=1, dy=1.
  - SERVE: the ball stays at centre and a frame counter runs. After SERVE_FRAMES ticks the FSM moves to PLAY.
  - PLAY: each tick, bx/by step by BALL_SPEED in their directions.
    - Wall: if dy=0 and by<BALL_SPEED, then by←0 and dy←1. If dy=1 and by+BALL_SPEED > 480−BALL_SIZE, then by←480−BALL_SIZE and dy←0.
    - Left paddle hit: dx=0, bx ≤ 16+PADDLE_W, bx+BALL_SIZE > 16, and the ball's y-range overlaps the paddle's y-range. Response: bx←16+PADDLE_W, dx←1.
    - Right paddle hit: mirror of the left, with bx←616−BALL_SIZE and dx←0.
    - Paddle hit takes priority over a miss. Wall and paddle reflection may occur on the same tick.
    - Miss: dx=0 and bx<BALL_SPEED increments `score_r`. dx=1 and bx+BALL_SPEED > 640−BALL_SIZE increments `score_l`. Either goes to POINT.
  - POINT: lasts one tick.
    - If the incremented score == WIN_SCORE, go to OVER.
    - Else re-centre the ball, set dx toward the scorer's opponent (the player who conceded), keep dy, and go to SERVE.
  - OVER: the ball is frozen and `game_over`=1. `start` clears both scores and goes to SERVE with dx=1, dy=1.
  - `start` is ignored in SERVE, PLAY and POINT.
- Draw priority: ball 12'hFFF, then left paddle 12'h0F0, then right paddle 12'h00F, then net (if compiled), then background 12'h000.

## Timing
- Reset values: `rgb`=0, `score_l`=`score_r`=0, `game_over`=0, state IDLE, paddles at 208, ball at (316,236), serve counter 0.
- Reset asserted mid-frame takes effect immediately. After release, the next update occurs on the next `frame_tick`.
- `rgb` latency: exactly 1 clock. The colour for the h_cnt/v_cnt presented at cycle N appears at cycle N+1.
- State updates at the `frame_tick` edge are visible in the next frame's pixels, with no tearing inside an active frame.

## Configuration
- `PONG_NET_EN` defined: a dashed centre net is drawn at x 319..320 where y[4]==0, colour 12'h888.
- `PONG_NET_EN` undefined: no net is drawn, and that logic is absent.

## Structure
- `pong_pkg` holds:
  - the FSM state enum;
  - the timing constants 144, 35, 640, 480 and frame end 799/524;
  - the colour constants;
  - the paddle x positions.
- Sub-module `pong_paddle`: one paddle's position register, button decode and clamping. It is instantiated twice.

## Test plan
- Reset, then check one frame: `rgb`=0 outside the active area. The pixel at h=144+316, v=35+236 gives 12'hFFF one cycle later. The pixel at x=640 with `enable` high gives 0.
- Assert `start`, then wait 60 frames: the FSM enters PLAY and bx increases by 2 per frame with dx=1.
- Hold `p1_up` for 60 frames: `pl_y` stops at 0. Hold both buttons: `pl_y` is unchanged.
- Place the ball with dy=0 and by=1: on the next tick by=0 and dy=1.
- Move the right paddle away and let the ball exit right: `score_l` goes to 1, the ball re-centres and dx=1 after SERVE. Repeat to 9: `game_over`=1. Then `start` clears the scores.
- Assert reset mid-PLAY: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the Pong display path.
// Holds the game FSM state enum, VGA timing constants (active origin, active size, frame end),
// draw colours and fixed paddle/ball reference positions.
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StServe,
    StPlay,
    StPoint,
    StOver
  } state_e;

  // VGA timing: active origin, active size and last counter values of a frame.
  localparam logic [11:0] HStart  = 12'd144;
  localparam logic [11:0] VStart  = 12'd35;
  localparam logic [11:0] ActiveW = 12'd640;
  localparam logic [11:0] ActiveH = 12'd480;
  localparam logic [11:0] HEnd    = 12'd799;
  localparam logic [11:0] VEnd    = 12'd524;

  // Colours, {R,G,B} 4 bits each.
  localparam logic [11:0] ColBall    = 12'hFFF;
  localparam logic [11:0] ColPaddleL = 12'h0F0;
  localparam logic [11:0] ColPaddleR = 12'h00F;
  localparam logic [11:0] ColNet     = 12'h888;
  localparam logic [11:0] ColBg      = 12'h000;

  // Geometry in active-area pixel coordinates.
  localparam logic [11:0] PaddleLX = 12'd16;
  localparam logic [11:0] PaddleRX = 12'd616;
  localparam logic [11:0] NetX     = 12'd319;
  localparam logic [9:0]  PaddleY0 = 10'd208;
  localparam logic [9:0]  BallCx   = 10'd316;
  localparam logic [9:0]  BallCy   = 10'd236;

endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle's vertical position.
// Ports: clk_i pixel clock, rst_ni async active-low reset, tick_i frame strobe,
//        up_i/down_i button levels (sampled on tick_i only), y_o paddle top (0..480-Height).
// Both or neither button held keeps the paddle still; the top is clamped at both ends.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int unsigned Speed  = 4,
  parameter int unsigned Height = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [9:0] y_o
);

  localparam logic [10:0] Sp   = 11'(Speed);
  localparam logic [10:0] YMax = 11'(ActiveH) - 11'(Height);

  logic [9:0]  y_q, y_d;
  logic [10:0] y_ext;

  // 11-bit arithmetic so neither direction can wrap before clamping.
  assign y_ext = {1'b0, y_q};

  always_comb begin
    y_d = y_q;
    if (up_i && !down_i) begin
      y_d = (y_ext < Sp) ? 10'd0 : 10'(y_ext - Sp);
    end else if (down_i && !up_i) begin
      y_d = (y_ext + Sp > YMax) ? 10'(YMax) : 10'(y_ext + Sp);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q <= PaddleY0;
    end else if (tick_i) begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_renderer.sv
// pong_renderer: Pong game engine and pixel generator.
// Inputs : clk (pixel clock), rst (async active-low), h_cnt/v_cnt/enable from VGA timing,
//          start, p1_up/p1_down (left player), p2_up/p2_down (right player).
// Outputs: rgb (registered, 1-cycle latency), score_l, score_r, game_over.
// Game state only changes on the frame_tick strobe at h_cnt==799, v_cnt==524, which lies
// outside the active area, so a frame is always drawn from one consistent state.
// Build option: define PONG_NET_EN to draw a dashed centre net.
module pong_renderer
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] h_cnt,
  input  logic [11:0] v_cnt,
  input  logic        enable,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  output logic [11:0] rgb,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);
  localparam logic [11:0] Bs   = 12'(BALL_SIZE);
  localparam logic [11:0] Sp   = 12'(BALL_SPEED);
  localparam logic [11:0] Pw   = 12'(PADDLE_W);
  localparam logic [11:0] Ph   = 12'(PADDLE_H);

  logic frame_tick;
  assign frame_tick = (h_cnt == HEnd) && (v_cnt == VEnd);

  logic [9:0] pl_y, pr_y;

  pong_paddle #(.Speed(PADDLE_SPEED), .Height(PADDLE_H)) u_paddle_l (
    .clk_i (clk),
    .rst_ni(rst),
    .tick_i(frame_tick),
    .up_i  (p1_up),
    .down_i(p1_down),
    .y_o   (pl_y)
  );

  pong_paddle #(.Speed(PADDLE_SPEED), .Height(PADDLE_H)) u_paddle_r (
    .clk_i (clk),
    .rst_ni(rst),
    .tick_i(frame_tick),
    .up_i  (p2_up),
    .down_i(p2_down),
    .y_o   (pr_y)
  );

  state_e          state_q;
  logic [9:0]      bx_q, by_q;
  logic            dx_q, dy_q;
  logic [CntW-1:0] serve_cnt_q;
  logic [3:0]      score_l_q, score_r_q;
  logic            game_over_q;
  logic [11:0]     rgb_q, rgb_d;

  logic [11:0] bx, by, ply, pry;
  assign bx  = {2'b00, bx_q};
  assign by  = {2'b00, by_q};
  assign ply = {2'b00, pl_y};
  assign pry = {2'b00, pr_y};

  // Vertical step with wall reflection.
  logic [9:0] by_step;
  logic       dy_step;
  always_comb begin
    by_step = by_q;
    dy_step = dy_q;
    if (!dy_q) begin
      if (by < Sp) begin
        by_step = 10'd0;
        dy_step = 1'b1;
      end else begin
        by_step = 10'(by - Sp);
      end
    end else if (by + Sp > ActiveH - Bs) begin
      by_step = 10'(ActiveH - Bs);
      dy_step = 1'b0;
    end else begin
      by_step = 10'(by + Sp);
    end
  end

  // Collision and miss detection use the pre-tick ball and paddle positions.
  logic hit_l, hit_r, miss_l, miss_r;
  assign hit_l  = !dx_q && (bx <= PaddleLX + Pw) && (bx + Bs > PaddleLX) &&
                  (by < ply + Ph) && (by + Bs > ply);
  assign hit_r  = dx_q && (bx + Bs >= PaddleRX) && (bx < PaddleRX + Pw) &&
                  (by < pry + Ph) && (by + Bs > pry);
  assign miss_l = !dx_q && (bx < Sp);
  assign miss_r = dx_q && (bx + Sp > ActiveW - Bs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bx_q        <= BallCx;
      by_q        <= BallCy;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      serve_cnt_q <= '0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      game_over_q <= 1'b0;
    end else if (frame_tick) begin
      case (state_q)
        StIdle: begin
          bx_q <= BallCx;
          by_q <= BallCy;
          if (start) begin
            state_q     <= StServe;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_cnt_q <= '0;
          end
        end
        StServe: begin
          if (serve_cnt_q == CntW'(SERVE_FRAMES - 1)) begin
            state_q     <= StPlay;
            serve_cnt_q <= '0;
          end else begin
            serve_cnt_q <= serve_cnt_q + CntW'(1);
          end
        end
        StPlay: begin
          by_q <= by_step;
          dy_q <= dy_step;
          if (hit_l) begin
            bx_q <= 10'(PaddleLX + Pw);
            dx_q <= 1'b1;
          end else if (hit_r) begin
            bx_q <= 10'(PaddleRX - Bs);
            dx_q <= 1'b0;
          end else if (miss_l) begin
            score_r_q <= score_r_q + 4'd1;
            state_q   <= StPoint;
          end else if (miss_r) begin
            score_l_q <= score_l_q + 4'd1;
            state_q   <= StPoint;
          end else begin
            bx_q <= dx_q ? 10'(bx + Sp) : 10'(bx - Sp);
          end
        end
        StPoint: begin
          // dx still points at the side that conceded, which is also the next serve direction.
          if ((dx_q ? score_l_q : score_r_q) == 4'(WIN_SCORE)) begin
            state_q     <= StOver;
            game_over_q <= 1'b1;
          end else begin
            bx_q        <= BallCx;
            by_q        <= BallCy;
            serve_cnt_q <= '0;
            state_q     <= StServe;
          end
        end
        StOver: begin
          if (start) begin
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            bx_q        <= BallCx;
            by_q        <= BallCy;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_cnt_q <= '0;
            game_over_q <= 1'b0;
            state_q     <= StServe;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pixel generation; counters below the active origin wrap to large values and fail x<640.
  logic [11:0] x, y;
  logic        active, ball_px, pl_px, pr_px;
  assign x       = h_cnt - HStart;
  assign y       = v_cnt - VStart;
  assign active  = enable && (x < ActiveW) && (y < ActiveH);
  assign ball_px = (x >= bx) && (x < bx + Bs) && (y >= by) && (y < by + Bs);
  assign pl_px   = (x >= PaddleLX) && (x < PaddleLX + Pw) && (y >= ply) && (y < ply + Ph);
  assign pr_px   = (x >= PaddleRX) && (x < PaddleRX + Pw) && (y >= pry) && (y < pry + Ph);

  always_comb begin
    rgb_d = ColBg;
    if (active) begin
      if (ball_px) rgb_d = ColBall;
      else if (pl_px) rgb_d = ColPaddleL;
      else if (pr_px) rgb_d = ColPaddleR;
`ifdef PONG_NET_EN
      else if (((x == NetX) || (x == NetX + 12'd1)) && !y[4]) rgb_d = ColNet;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= ColBg;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_renderer.sv
// tb_pong_renderer: scoreboard bench for pong_renderer.
// The bench drives h_cnt/v_cnt directly, so a "frame" is a few probe pixels followed by one
// frame_tick cycle. A behavioural game model predicts every pixel colour and score.
module tb_pong_renderer;

  localparam int HS = 144, VS = 35, W = 640, H = 480;
  localparam int BSZ = 8, PW = 8, PH = 64, PSP = 4, BSP = 2, WIN = 9, SRV = 60;
  localparam int LX = 16, RX = 616, CX = 316, CY = 236;
  localparam int MIdle = 0, MServe = 1, MPlay = 2, MPoint = 3, MOver = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] h_cnt = '0, v_cnt = '0;
  logic        enable = 1'b0, start = 1'b0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [11:0] rgb;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  always #20 clk = ~clk;

  pong_renderer dut (
    .clk      (clk),
    .rst      (rst),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .enable   (enable),
    .start    (start),
    .p1_up    (p1_up),
    .p1_down  (p1_down),
    .p2_up    (p2_up),
    .p2_down  (p2_down),
    .rgb      (rgb),
    .score_l  (score_l),
    .score_r  (score_r),
    .game_over(game_over)
  );

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    int          sl;
    int          sr;
    bit          go;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Game model state.
  int m_st, m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_cnt, m_sl, m_sr;
  bit m_left_scored;

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic bit in_rect(int x, int y, int rx, int ry, int rw, int rh);
    return (x >= rx) && (x < rx + rw) && (y >= ry) && (y < ry + rh);
  endfunction

  function automatic bit spans_overlap(int a, int alen, int b, int blen);
    return (a < b + blen) && (b < a + alen);
  endfunction

  function automatic logic [11:0] exp_pix(int h, int v, bit en);
    int x, y;
    x = h - HS;
    y = v - VS;
    if (!en || x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
    if (in_rect(x, y, m_bx, m_by, BSZ, BSZ)) return 12'hFFF;
    if (in_rect(x, y, LX, m_pl, PW, PH)) return 12'h0F0;
    if (in_rect(x, y, RX, m_pr, PW, PH)) return 12'h00F;
`ifdef PONG_NET_EN
    if ((x == 319 || x == 320) && ((y / 16) % 2 == 0)) return 12'h888;
`endif
    return 12'h000;
  endfunction

  task automatic model_reset();
    m_st = MIdle; m_pl = 208; m_pr = 208; m_bx = CX; m_by = CY;
    m_dx = 1; m_dy = 1; m_cnt = 0; m_sl = 0; m_sr = 0; m_left_scored = 1'b0;
  endtask

  task automatic model_tick(input bit st, input logic [3:0] btn);
    int opl, opr, oby, nbx, nby, ndy;
    opl = m_pl;
    opr = m_pr;
    oby = m_by;
    m_pl = clamp(m_pl + PSP * (int'(btn[2]) - int'(btn[3])), 0, H - PH);
    m_pr = clamp(m_pr + PSP * (int'(btn[0]) - int'(btn[1])), 0, H - PH);
    case (m_st)
      MIdle: if (st) begin m_st = MServe; m_dx = 1; m_dy = 1; m_cnt = 0; end
      MServe: begin
        m_cnt++;
        if (m_cnt == SRV) begin m_st = MPlay; m_cnt = 0; end
      end
      MPlay: begin
        nby = oby + (m_dy != 0 ? BSP : -BSP);
        ndy = m_dy;
        if (nby < 0) begin nby = 0; ndy = 1; end
        else if (nby > H - BSZ) begin nby = H - BSZ; ndy = 0; end
        nbx = m_bx + (m_dx != 0 ? BSP : -BSP);
        if (m_dx == 0 && spans_overlap(m_bx, BSZ, LX, PW + 1) &&
            spans_overlap(oby, BSZ, opl, PH)) begin
          m_bx = LX + PW; m_dx = 1;
        end else if (m_dx == 1 && spans_overlap(m_bx, BSZ + 1, RX, PW) &&
                     spans_overlap(oby, BSZ, opr, PH)) begin
          m_bx = RX - BSZ; m_dx = 0;
        end else if (nbx < 0) begin
          m_sr++; m_left_scored = 1'b0; m_st = MPoint;
        end else if (nbx > W - BSZ) begin
          m_sl++; m_left_scored = 1'b1; m_st = MPoint;
        end else begin
          m_bx = nbx;
        end
        m_by = nby;
        m_dy = ndy;
      end
      MPoint: begin
        if ((m_left_scored ? m_sl : m_sr) == WIN) begin
          m_st = MOver;
        end else begin
          m_bx = CX; m_by = CY; m_cnt = 0; m_st = MServe;
          m_dx = m_left_scored ? 1 : 0;
        end
      end
      MOver: if (st) begin
        m_sl = 0; m_sr = 0; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1; m_cnt = 0; m_st = MServe;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_exp(input int h, input int v, input logic [11:0] px);
    exp_t e;
    e.h = h; e.v = v; e.rgb = px; e.sl = m_sl; e.sr = m_sr; e.go = (m_st == MOver);
    exp_q.push_back(e);
  endtask

  // One non-tick pixel; buttons and start toggle randomly and must be ignored.
  task automatic probe(input int h, input int v, input bit en);
    @(negedge clk);
    h_cnt = 12'(h);
    v_cnt = 12'(v);
    enable = en;
    {start, p1_up, p1_down, p2_up, p2_down} = 5'($urandom);
    push_exp(h, v, exp_pix(h, v, en));
  endtask

  // btn = {p1_up, p1_down, p2_up, p2_down}
  task automatic tick(input bit st, input logic [3:0] btn);
    logic [11:0] px;
    @(negedge clk);
    h_cnt = 12'd799;
    v_cnt = 12'd524;
    enable = 1'($urandom);
    start = st;
    {p1_up, p1_down, p2_up, p2_down} = btn;
    px = exp_pix(799, 524, enable);
    model_tick(st, btn);
    push_exp(799, 524, px);
  endtask

  task automatic frame(input bit st, input logic [3:0] btn);
    int h, v;
    probe(HS + m_bx, VS + m_by, 1'b1);
    if ($urandom_range(0, 1) == 0) probe(HS + m_bx - 1, VS + m_by + int'($urandom_range(0, 7)), 1'b1);
    else probe(HS + m_bx + BSZ, VS + m_by + int'($urandom_range(0, 7)), 1'b1);
    if ($urandom_range(0, 1) == 0)
      probe(HS + LX + int'($urandom_range(0, PW)), VS + m_pl - 1 + int'($urandom_range(0, PH + 1)), 1'b1);
    else
      probe(HS + RX - 1 + int'($urandom_range(0, PW)), VS + m_pr - 1 + int'($urandom_range(0, PH + 1)),
            1'b1);
    h = int'($urandom_range(0, 799));
    v = int'($urandom_range(0, 524));
    if (h == 799 && v == 524) v = 0;
    probe(h, v, 1'($urandom));
    tick(st, btn);
  endtask

  // Tracking follows the ball; avoiding moves away from it.
  task automatic steer(input int p, input bit track, output bit up, output bit dn);
    int pc, bc;
    pc = p + PH / 2;
    bc = m_by + BSZ / 2;
    up = 1'b0;
    dn = 1'b0;
    if (track) begin
      if (bc < pc - 2) up = 1'b1;
      else if (bc > pc + 2) dn = 1'b1;
    end else if (bc >= pc) up = 1'b1;
    else dn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, rgb, 12'h000);
    check({tag, "_score_l"}, {8'h00, score_l}, 12'h000);
    check({tag, "_score_r"}, {8'h00, score_r}, 12'h000);
    check({tag, "_game_over"}, {11'h000, game_over}, 12'h000);
  endtask

  // Monitor: one registered pixel per cycle, checked just after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("rgb h=%0d v=%0d", e.h, e.v), rgb, e.rgb);
        check("score_l", {8'h00, score_l}, 12'(e.sl));
        check("score_r", {8'h00, score_r}, 12'(e.sr));
        check("game_over", {11'h000, game_over}, {11'h000, e.go});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit u1, d1, u2, d2, trk_r;
    model_reset();
    #5 rst = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Boundary pixels in IDLE.
    probe(HS + CX, VS + CY, 1'b1);
    probe(HS + CX, VS + CY, 1'b0);
    probe(HS + W, VS + CY, 1'b1);
    probe(HS + W - 1, VS + CY, 1'b1);
    probe(HS + CX, VS + H, 1'b1);
    probe(HS + LX, VS + 208, 1'b1);
    probe(HS + RX + PW - 1, VS + 208 + PH - 1, 1'b1);
    probe(HS + RX + PW, VS + 208, 1'b1);
    probe(HS + CX + BSZ, VS + CY, 1'b1);
    probe(HS - 1, VS + CY, 1'b1);

    repeat (8) frame(1'b0, 4'($urandom));
    repeat (60) frame(1'b0, 4'b1001);  // p1 up, p2 down: both clamp
    repeat (5) frame(1'b0, 4'b1111);   // both buttons held: no motion
    frame(1'b1, 4'b0000);              // start

    // First point: right tracks, left avoids. Afterwards the roles swap.
    for (int f = 0; f < 6000 && m_st != MOver; f++) begin
      trk_r = (m_sl == 0 && m_sr == 0);
      steer(m_pl, !trk_r, u1, d1);
      steer(m_pr, trk_r, u2, d2);
      frame($urandom_range(0, 7) == 0, {u1, d1, u2, d2});
    end
    @(posedge clk);
    #2 check("game_over_reached", {11'h000, game_over}, 12'h001);

    repeat (3) frame(1'b0, 4'($urandom));
    frame(1'b1, 4'($urandom));  // restart clears scores
    repeat (SRV + 6) frame(1'b0, 4'($urandom));

    // Reset in the middle of PLAY with the ball pixel on the output.
    probe(HS + m_bx, VS + m_by, 1'b1);
    @(posedge clk);
    #5 rst = 1'b0;
    #2 check_reset_outputs("midplay_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) frame(1'b0, 4'b0000);

    @(posedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
